// File: rtl/aes_sched_pkg.sv
// Shared types and widths for the AES request scheduler.
package aes_sched_pkg;

  localparam int unsigned AES_W = 128;

  typedef logic [AES_W-1:0] aes_block_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // One decryption job as handed to the core.
  typedef struct packed {
    aes_block_t key;
    aes_block_t msg;
  } aes_job_t;

endpackage

// File: rtl/aes_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after rr_ptr.
module aes_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned REQ_IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [REQ_IDX_W-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]   grant,
  output logic [REQ_IDX_W-1:0] grant_idx
);

  // One extra bit so rr_ptr + offset cannot overflow before the wrap.
  localparam int unsigned POS_W = REQ_IDX_W + 1;

  logic [POS_W-1:0] pos;
  logic             found;

  // Scan NUM_REQ positions starting at rr_ptr, keep the first valid one.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      pos = {1'b0, rr_ptr} + POS_W'(off);
      if (pos >= POS_W'(NUM_REQ)) begin
        pos = pos - POS_W'(NUM_REQ);
      end
      if (!found && req_valid[pos[REQ_IDX_W-1:0]]) begin
        found                       = 1'b1;
        grant[pos[REQ_IDX_W-1:0]]   = 1'b1;
        grant_idx                   = pos[REQ_IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/aes_req_scheduler.sv
// Shares one AES-128 decryption core between NUM_REQ requesters with a
// round-robin grant, a level START/DONE handshake and a hang watchdog.
module aes_req_scheduler
  import aes_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0][AES_W-1:0] req_key,
  input  logic [NUM_REQ-1:0][AES_W-1:0] req_msg,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic                          resp_err,
  output logic [AES_W-1:0]              resp_msg,
  output logic                          busy,
  output logic                          AES_START,
  input  logic                          AES_DONE,
  output logic [AES_W-1:0]              AES_KEY,
  output logic [AES_W-1:0]              AES_MSG_ENC,
  input  logic [AES_W-1:0]              AES_MSG_DEC
);

  localparam int unsigned REQ_IDX_W = $clog2(NUM_REQ);
  localparam int unsigned WD_W      = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]      WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [REQ_IDX_W-1:0] LAST_IDX = REQ_IDX_W'(NUM_REQ - 1);

  state_t                 state;
  state_t                 state_nxt;
  logic [REQ_IDX_W-1:0]   rr_ptr;
  logic [REQ_IDX_W-1:0]   owner;
  logic [REQ_IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0]     grant;
  logic [WD_W-1:0]        wd_cnt;
  aes_job_t               job;
  logic                   take;
  logic                   finish_ok;
  logic                   finish_tmo;

  aes_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign AES_KEY     = job.key;
  assign AES_MSG_ENC = job.msg;

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: grant leaves IDLE, done or watchdog leaves RUN, DRAIN waits for DONE low.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|grant) state_nxt = RUN;
      RUN:     if (AES_DONE || (wd_cnt == WD_LAST)) state_nxt = DRAIN;
      DRAIN:   if (!AES_DONE) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state strobes; req_ready is the live arbiter pick while idle and out of reset.
  always_comb begin
    req_ready  = '0;
    take       = 1'b0;
    finish_ok  = 1'b0;
    finish_tmo = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (!RESET) begin
          req_ready = grant;
          take      = |grant;
        end
      end
      RUN: begin
        finish_ok  = AES_DONE;
        finish_tmo = !AES_DONE && (wd_cnt == WD_LAST);
      end
      default: ;
    endcase
  end

  // Latch the granted job and advance the round-robin pointer past the winner.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      job    <= '0;
      owner  <= '0;
      rr_ptr <= '0;
    end else if (take) begin
      job.key <= req_key[grant_idx];
      job.msg <= req_msg[grant_idx];
      owner   <= grant_idx;
      rr_ptr  <= (grant_idx == LAST_IDX) ? '0 : grant_idx + REQ_IDX_W'(1);
    end
  end

  // Watchdog: cleared on grant, counts every RUN cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wd_cnt <= '0;
    end else if (take) begin
      wd_cnt <= '0;
    end else if (state == RUN) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  // Core start level: raised on grant, dropped on the response edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      AES_START <= 1'b0;
    end else if (take) begin
      AES_START <= 1'b1;
    end else if (finish_ok || finish_tmo) begin
      AES_START <= 1'b0;
    end
  end

  // Response: one-cycle pulse to the owner; data and error held until the next one.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      resp_valid <= '0;
      resp_err   <= 1'b0;
      resp_msg   <= '0;
    end else begin
      resp_valid <= '0;
      if (finish_ok) begin
        resp_valid[owner] <= 1'b1;
        resp_err          <= 1'b0;
        resp_msg          <= AES_MSG_DEC;
      end else if (finish_tmo) begin
        resp_valid[owner] <= 1'b1;
        resp_err          <= 1'b1;
        resp_msg          <= '0;
      end
    end
  end

endmodule

// File: tb/tb_aes_req_scheduler.sv
// Self-checking bench: behavioural core model, cycle reference model and directed scenarios.
module tb_aes_req_scheduler;

  localparam int unsigned N = 3;
  localparam int unsigned T = 16;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K0 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] M0 = 128'h1111222233334444555566667777aaaa;
  localparam logic [127:0] K1 = 128'hdeadbeef0123456789abcdeffedcba98;
  localparam logic [127:0] M1 = 128'hcafef00d5555aaaa12345678a5a5c3c3;

  logic                  CLK;
  logic                  RESET;
  logic [N-1:0]          req_valid;
  logic [N-1:0][127:0]   req_key;
  logic [N-1:0][127:0]   req_msg;
  logic [N-1:0]          req_ready;
  logic [N-1:0]          resp_valid;
  logic                  resp_err;
  logic [127:0]          resp_msg;
  logic                  busy;
  logic                  AES_START;
  logic                  AES_DONE;
  logic [127:0]          AES_KEY;
  logic [127:0]          AES_MSG_ENC;
  logic [127:0]          AES_MSG_DEC;

  aes_req_scheduler #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .req_valid   (req_valid),
    .req_key     (req_key),
    .req_msg     (req_msg),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_err    (resp_err),
    .resp_msg    (resp_msg),
    .busy        (busy),
    .AES_START   (AES_START),
    .AES_DONE    (AES_DONE),
    .AES_KEY     (AES_KEY),
    .AES_MSG_ENC (AES_MSG_ENC),
    .AES_MSG_DEC (AES_MSG_DEC)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // core model knobs
  int core_lat = 3;
  int core_drop = 0;
  bit core_hang = 1'b0;
  bit core_rand = 1'b0;

  // observation logs
  int           grant_q[$];
  int           resp_owner_q[$];
  int           resp_err_q[$];
  int           resp_dt_q[$];
  int           resp_start_q[$];
  logic [127:0] resp_msg_q[$];
  int           start_cyc = 0;
  logic         prev_start = 1'b0;
  logic [N-1:0] last_grant = '0;

  // reference model state
  bit           m_job, m_drain, m_start, m_rerr;
  int           m_ptr, m_owner, m_age;
  logic [127:0] m_key, m_msg, m_rmsg;
  logic [N-1:0] m_rvalid;
  int           g;
  logic [N-1:0] exp_ready;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [127:0] core_plain(input logic [127:0] k, input logic [127:0] c);
    if (k == FIPS_KEY && c == FIPS_CT) return FIPS_PT;
    return k ^ {c[63:0], c[127:64]};
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    for (int o = 0; o < int'(N); o++) begin
      int i;
      i = (ptr + o) % int'(N);
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < int'(N); i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int qi(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -99;
  endfunction

  function automatic logic [127:0] qm(input logic [127:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return '1;
  endfunction

  task automatic m_reset();
    m_job = 0; m_drain = 0; m_start = 0; m_rerr = 0;
    m_ptr = 0; m_owner = 0; m_age = 0;
    m_key = '0; m_msg = '0; m_rmsg = '0; m_rvalid = '0;
  endtask

  // Advance the reference by one clock edge using the inputs present now.
  task automatic m_step(input int pick);
    m_rvalid = '0;
    if (m_job) begin
      if (AES_DONE) begin
        m_rmsg = AES_MSG_DEC; m_rerr = 0; m_rvalid[m_owner] = 1'b1;
        m_start = 0; m_job = 0; m_drain = 1;
      end else if (m_age == int'(T) - 1) begin
        m_rmsg = '0; m_rerr = 1; m_rvalid[m_owner] = 1'b1;
        m_start = 0; m_job = 0; m_drain = 1;
      end
      m_age++;
    end else if (m_drain) begin
      if (!AES_DONE) m_drain = 0;
    end else if (pick >= 0) begin
      m_key = req_key[pick]; m_msg = req_msg[pick]; m_owner = pick;
      m_ptr = (pick + 1) % int'(N); m_start = 1; m_age = 0; m_job = 1;
    end
  endtask

  // Compare process: snapshot just after each falling edge, inputs for the next rising edge are set.
  initial begin : chk_proc
    m_reset();
    forever begin
      @(negedge CLK);
      #1;
      cyc++;
      if (RESET) m_reset();
      g = (RESET || m_job || m_drain) ? -1 : rr_pick(req_valid, m_ptr);
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      check("req_ready", 128'(req_ready), 128'(exp_ready));
      check("busy", 128'(busy), 128'(m_job | m_drain));
      check("AES_START", 128'(AES_START), 128'(m_start));
      check("AES_KEY", AES_KEY, m_key);
      check("AES_MSG_ENC", AES_MSG_ENC, m_msg);
      check("resp_valid", 128'(resp_valid), 128'(m_rvalid));
      check("resp_err", 128'(resp_err), 128'(m_rerr));
      check("resp_msg", resp_msg, m_rmsg);
      if (!RESET) begin
        if (AES_START && !prev_start) start_cyc = cyc;
        if (req_ready != '0) grant_q.push_back(oh_idx(req_ready));
        if (resp_valid != '0) begin
          resp_owner_q.push_back(oh_idx(resp_valid));
          resp_err_q.push_back(int'(resp_err));
          resp_msg_q.push_back(resp_msg);
          resp_dt_q.push_back(cyc - start_cyc);
          resp_start_q.push_back(int'(AES_START));
        end
      end
      prev_start = AES_START;
      last_grant = RESET ? '0 : req_ready;
      if (!RESET) m_step(g);
    end
  end

  // AES core model: DONE after core_lat START cycles, held while START, dropped core_drop cycles later.
  initial begin : core_model
    int cnt;
    int dropc;
    cnt = 0;
    dropc = 0;
    AES_DONE = 1'b0;
    AES_MSG_DEC = '0;
    forever begin
      @(posedge CLK);
      #2;
      if (RESET) begin
        AES_DONE = 1'b0; cnt = 0; dropc = 0;
      end else if (AES_START) begin
        if (!AES_DONE) begin
          if (cnt == 0 && core_rand) begin
            core_lat = int'($urandom_range(1, 20));
            core_drop = int'($urandom_range(0, 3));
          end
          cnt++;
          if (!core_hang && cnt >= core_lat) begin
            AES_DONE = 1'b1;
            AES_MSG_DEC = core_plain(AES_KEY, AES_MSG_ENC);
          end
        end
      end else begin
        cnt = 0;
        if (AES_DONE) begin
          if (dropc >= core_drop) begin
            AES_DONE = 1'b0; dropc = 0;
            AES_MSG_DEC = {$urandom, $urandom, $urandom, $urandom};
          end else begin
            dropc++;
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge CLK);
    req_valid = req_valid & ~last_grant;
  endtask

  task automatic post(input int i, input logic [127:0] k, input logic [127:0] m);
    req_key[i] = k;
    req_msg[i] = m;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_quiet(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || req_valid != '0 || AES_DONE) && n < budget) begin
      step();
      n++;
    end
    check_int({name, " quiet within budget"}, int'(n < budget), 1);
  endtask

  task automatic clear_logs();
    grant_q.delete(); resp_owner_q.delete(); resp_err_q.delete();
    resp_msg_q.delete(); resp_dt_q.delete(); resp_start_q.delete();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    req_valid = '0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL global time limit reached");
    $fatal(1, "bench stalled");
  end

  initial begin : stim
    int n;
    RESET = 1'b1;
    req_valid = '0;
    req_key = '0;
    req_msg = '0;
    @(negedge CLK);
    #2;
    check("reset resp_msg", resp_msg, 128'h0);
    check("reset AES_START", 128'(AES_START), 128'h0);
    do_reset();

    // single job with the FIPS-197 vector
    clear_logs();
    core_lat = 3; core_drop = 1; core_hang = 0;
    post(0, FIPS_KEY, FIPS_CT);
    wait_quiet("t1", 100);
    check_int("t1 grant count", grant_q.size(), 1);
    check_int("t1 grant idx", qi(grant_q, 0), 0);
    check_int("t1 resp owner", qi(resp_owner_q, 0), 0);
    check_int("t1 resp err", qi(resp_err_q, 0), 0);
    check("t1 resp msg", qm(resp_msg_q, 0), FIPS_PT);
    check_int("t1 start-to-resp", qi(resp_dt_q, 0), 3);

    // simultaneous requests rotate 0,1,0,1
    do_reset();
    clear_logs();
    core_lat = 2; core_drop = 0;
    post(0, K0, M0); post(1, K1, M1);
    wait_quiet("t2a", 200);
    post(0, K1, M0); post(1, K0, M1);
    wait_quiet("t2b", 200);
    check_int("t2 grant count", grant_q.size(), 4);
    check_int("t2 grant 0", qi(grant_q, 0), 0);
    check_int("t2 grant 1", qi(grant_q, 1), 1);
    check_int("t2 grant 2", qi(grant_q, 2), 0);
    check_int("t2 grant 3", qi(grant_q, 3), 1);

    // request raised mid-job waits and keeps its data
    clear_logs();
    core_lat = 10; core_drop = 2;
    post(0, K0, M0);
    repeat (4) step();
    post(1, K1, M1);
    repeat (2) step();
    check_int("t3 ready1 held low", int'(req_ready[1]), 0);
    check("t3 key stable", AES_KEY, K0);
    wait_quiet("t3", 200);
    check_int("t3 first grant", qi(grant_q, 0), 0);
    check_int("t3 second grant", qi(grant_q, 1), 1);
    check("t3 resp0 msg", qm(resp_msg_q, 0), core_plain(K0, M0));
    check_int("t3 resp1 owner", qi(resp_owner_q, 1), 1);
    check("t3 resp1 msg", qm(resp_msg_q, 1), core_plain(K1, M1));

    // hung core: abort exactly T cycles after the START rise
    clear_logs();
    core_hang = 1;
    post(2, K1, M0);
    wait_quiet("t4", 200);
    check_int("t4 resp owner", qi(resp_owner_q, 0), 2);
    check_int("t4 resp err", qi(resp_err_q, 0), 1);
    check("t4 resp msg", qm(resp_msg_q, 0), 128'h0);
    check_int("t4 start-to-resp", qi(resp_dt_q, 0), 16);
    check_int("t4 start low at resp", qi(resp_start_q, 0), 0);
    core_hang = 0;

    // DONE on the last watchdog cycle wins; one cycle later is a timeout
    clear_logs();
    core_lat = 16; core_drop = 0;
    post(0, K0, M1);
    wait_quiet("t5a", 200);
    core_lat = 17;
    post(1, K1, M0);
    wait_quiet("t5b", 200);
    check_int("t5 tie err", qi(resp_err_q, 0), 0);
    check("t5 tie msg", qm(resp_msg_q, 0), core_plain(K0, M1));
    check_int("t5 tie start-to-resp", qi(resp_dt_q, 0), 16);
    check_int("t5 late err", qi(resp_err_q, 1), 1);
    check_int("t5 late start-to-resp", qi(resp_dt_q, 1), 16);

    // reset five cycles into a job
    do_reset();
    core_lat = 20; core_drop = 0;
    post(1, K1, M1);
    n = 0;
    while (!AES_START && n < 20) begin
      step();
      n++;
    end
    check_int("t6 job started", int'(AES_START), 1);
    repeat (5) step();
    post(2, K0, M0);
    clear_logs();
    @(negedge CLK);
    RESET = 1'b1;
    #2;
    check_int("t6 start async low", int'(AES_START), 0);
    check_int("t6 busy async low", int'(busy), 0);
    check_int("t6 resp_valid low", int'(resp_valid), 0);
    req_valid = '0;
    repeat (2) @(negedge CLK);
    check_int("t6 no response", resp_owner_q.size(), 0);
    RESET = 1'b0;
    clear_logs();
    post(1, K1, M0); post(0, K0, M1);
    wait_quiet("t6", 200);
    check_int("t6 first grant after reset", qi(grant_q, 0), 0);
    check_int("t6 second grant after reset", qi(grant_q, 1), 1);

    // randomized traffic, including withdrawn requests and timeouts
    core_rand = 1;
    for (int c = 0; c < 2500; c++) begin
      step();
      for (int i = 0; i < int'(N); i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 7) == 0)
            post(i, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        end else if ($urandom_range(0, 39) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    wait_quiet("random drain", 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_req_scheduler.md
# aes_req_scheduler

Round-robin scheduler that shares the single AES-128 decryption core (`AES`) between `NUM_REQ` requesters. It accepts (key, ciphertext) jobs through a valid/ready handshake and latches them. It sequences the core's level-sensitive `AES_START`/`AES_DONE` protocol and returns the plaintext to the owning requester. A watchdog aborts jobs when the core hangs. It sits between the Avalon/NIOS-facing request logic and the `AES` instance.

## Interface
- `NUM_REQ`, 2, number of requesters (2..8)
- `TIMEOUT_CYCLES`, 1024, maximum RUN cycles before abort (≥ 2)

- `CLK`  in  1  system clock
- `RESET`  in  1  asynchronous, active-high reset
- `req_valid`  in  NUM_REQ  per-requester job request
- `req_key`  in  NUM_REQ×128  per-requester key; stable while `req_valid`
- `req_msg`  in  NUM_REQ×128  per-requester ciphertext; stable while `req_valid`
- `req_ready`  out  NUM_REQ  one-hot accept; combinational in IDLE
- `resp_valid`  out  NUM_REQ  one-cycle completion pulse to job owner
- `resp_err`  out  1  qualifies `resp_valid`; 1 = timeout abort
- `resp_msg`  out  128  plaintext; held until next response
- `busy`  out  1  high in any state other than IDLE
- `AES_START`  out  1  core start; level, registered
- `AES_DONE`  in  1  core done; held high by core while `AES_START` is high
- `AES_KEY`  out  128  latched key to core
- `AES_MSG_ENC`  out  128  latched ciphertext to core
- `AES_MSG_DEC`  in  128  core plaintext; valid while `AES_DONE`

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE
  - Round-robin search starts at `rr_ptr` (reset 0).
  - First index i with `req_valid[i]` gets `req_ready[i]`=1 in the same cycle.
  - At that edge: latch `req_key[i]`/`req_msg[i]` into `AES_KEY`/`AES_MSG_ENC`, `owner`←i, `rr_ptr`←(i+1) mod NUM_REQ, `AES_START`←1, `wd_cnt`←0, go to RUN.
  - With no valid request, stay in IDLE; `rr_ptr` is unchanged.
- RUN
  - `wd_cnt` increments each cycle.
  - If `AES_DONE`=1: `resp_msg`←`AES_MSG_DEC`, `resp_err`←0, `resp_valid[owner]`←1, `AES_START`←0, go to DRAIN.
  - Else if `wd_cnt`=TIMEOUT_CYCLES−1: `resp_msg`←0, `resp_err`←1, `resp_valid[owner]`←1, `AES_START`←0, go to DRAIN.
  - When both conditions hold in the same cycle, DONE wins.
- DRAIN: wait for `AES_DONE`=0, then go to IDLE. This guarantees `AES_START` is never re-raised while the core still reports done.
- `req_ready` is 0 outside IDLE. New requests wait; they are never dropped.
- `AES_KEY`/`AES_MSG_ENC` are stable from the START rise until the next grant.
- A requester that drops `req_valid` before its grant is simply skipped.

## Timing
- Reset values:
  - State IDLE, `AES_START` 0, `req_ready` 0, `resp_valid` 0, `resp_err` 0.
  - `resp_msg`, `AES_KEY`, `AES_MSG_ENC` all 0; `busy` 0; `rr_ptr` 0; `wd_cnt` 0.
- Grant to `AES_START` high: 1 cycle (edge after `req_ready`).
- `AES_DONE` seen to `resp_valid` pulse: 1 cycle. `AES_START` falls on the same edge.
- Minimum job-to-job spacing: grant, N core cycles, 1 response cycle, DRAIN until `AES_DONE` low, then 1 IDLE grant cycle.
- Reset mid-RUN: `AES_START` drops immediately (async), no `resp_valid` is issued, and the latched job is lost. The core shares `RESET`.
- `resp_valid` is exactly one cycle wide and never asserted to more than one requester.

## Structure
- Package `aes_sched_pkg`:
  - `state_t` enum {IDLE, RUN, DRAIN}
  - `localparam AES_W = 128`
  - width helper `REQ_IDX_W = $clog2(NUM_REQ)` computed locally
- Sub-module `aes_rr_arbiter`: combinational round-robin pick. Inputs `req_valid` and `rr_ptr`; outputs one-hot `grant` and `grant_idx`. `rr_ptr` stays in the parent.
- Watchdog counter and FSM live in the top. Target 150–250 lines total.

## Test plan
- Single job: requester 0 sends key 000102030405060708090a0b0c0d0e0f with ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a. Required response: `req_ready[0]` for 1 cycle, `AES_START` the next cycle, `resp_valid[0]` with `resp_msg`=00112233445566778899aabbccddeeff and `resp_err`=0, then `busy` falls after `AES_DONE` drops.
- Simultaneous requests: requesters 0 and 1 valid in the same cycle after reset. Required response: 0 is granted first and 1 second. Repeating the pair yields 0, 1, 0, 1 (`rr_ptr` rotation).
- Hold during RUN: requester 1 raises `req_valid` mid-job. Required response: `req_ready[1]` stays 0 until IDLE, and the job is then granted with its data intact. `AES_KEY` is unchanged throughout the first job.
- Timeout: core model never asserts DONE, with `TIMEOUT_CYCLES`=16. Required response: `resp_valid[owner]`=1, `resp_err`=1, `resp_msg`=0 exactly 16 cycles after the START rise, and `AES_START`=0 on the same edge.
- DONE/timeout tie: DONE arrives on the last watchdog cycle. Required response: `resp_err`=0 and the plaintext is delivered.
- Reset mid-RUN: assert `RESET` 5 cycles into a job. Required response: `AES_START`, `busy`, and all `resp_valid` go to 0 immediately with no response pulse. After release, requester 0 is granted first (`rr_ptr`=0).
